aes_frame_uart_initiator: RTL
=============================

# aes_frame_uart_initiator

Host-side initiator for the hybrid RSA/AES UART decrypt link. On `start` it serializes a 32-byte request frame over `uart_tx`: 16 bytes of RSA-wrapped AES key, then 16 bytes of AES ciphertext. It then collects the 16-byte plaintext response from `uart_rx` and presents it as a 128-bit word. It sits opposite the Basys3 decrypt top, for board-to-board tests and for self-checking loopback builds.

## Interface
- `CLK_HZ`, 100_000_000, clock frequency in Hz
- `BAUD`, 115200, line rate
- `BAUD_TICKS`, CLK_HZ/BAUD (868), clocks per bit, integer division
- `RESP_TIMEOUT`, 2_000_000, max idle clocks allowed before each response byte
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  request a transaction; honoured only when `busy`=0
- `key_ct`  in  128  RSA ciphertext of AES key; latched on accepted `start`
- `data_ct`  in  128  AES ciphertext block; latched on accepted `start`
- `uart_rx`  in  1  serial response line from the responder, asynchronous
- `uart_tx`  out  1  serial request line to the responder, idle high
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle pulse at end of transaction, success or timeout
- `plaintext`  out  128  received response, byte 0 in [127:120]
- `err_timeout`  out  1  last transaction ended on response timeout
- `err_frame`  out  1  at least one response byte had a low stop bit

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `plaintext`=0, `err_timeout`=0, `err_frame`=0. Both FSMs go to IDLE and the rx synchronizer is preset to 1.
- `start` accepted in IDLE, including the cycle `done` pulses. On acceptance:
  - latch {`key_ct`,`data_ct`} into a 256-bit shift register;
  - clear `plaintext`, `err_*` and the rx byte count.
- Byte order: MSB-first. Byte k comes from bits [255-8k -: 8], so `key_ct`[127:120] is sent first.
- Tx FSM states: IDLE → GAP → START → DATA → STOP.
  - GAP: 1 bit time high; START: 1 bit time low; DATA: 8 bit times, LSB first; STOP: 1 bit time high.
  - Each byte takes 11 bit times. After STOP, go to GAP if bytes remain, else RESP.
- Rx path: 2-flop synchronizer, then rx FSM R_IDLE → R_START → R_DATA → R_STOP.
  - R_IDLE: waits for a falling edge.
  - R_START: samples at BAUD_TICKS/2. If the line is high, it is a false start; return to R_IDLE.
  - R_DATA: samples 8 bits, each BAUD_TICKS apart, LSB first.
  - R_STOP: samples the stop bit. If low, set `err_frame`; the byte is still stored.
  - Rx FSM enabled only in RESP. Falling edges before RESP are ignored.
- RESP state:
  - Byte n (0..15) is written to `plaintext`[127-8n -: 8].
  - A timeout counter resets on entering RESP and on each stored byte; it is held while a byte is being received.
  - Reaching RESP_TIMEOUT sets `err_timeout` and ends the transaction. `plaintext` keeps the partial bytes.
- End of transaction (16th byte stored, or timeout): pulse `done`, drop `busy`, return to IDLE. Outputs hold until the next accepted `start`.
- `start` while `busy`=1 is ignored, with no queueing. `key_ct`/`data_ct` changes after acceptance have no effect.

## Timing
- Accepted `start` at cycle 0. `busy`=1 from cycle 1.
- First start bit: `uart_tx` falls at cycle 1+BAUD_TICKS.
- Bit edges every BAUD_TICKS exactly, with no drift across the frame.
- Request frame lasts 32·11·BAUD_TICKS = 305,536 cycles at the defaults; RESP is entered the cycle after the last stop bit ends.
- Rx latency: 2 sync cycles plus sampling points at falling edge+2+BAUD_TICKS/2+m·BAUD_TICKS, for m=0 (start), 1..8 (data), 9 (stop).
- The stop sample of byte 15 stores the byte. `done`=1 and `busy`=0 on the next cycle.
- Reset mid-frame takes effect on the next edge: `uart_tx`=1 immediately, and the truncated byte is not resumed.

## Test plan
- Loopback responder model that returns 16 bytes 5 bit times after the last stop bit; `key_ct`=12345678987654321234567898765432, `data_ct`=08938A533D49A4F5DD8C42A3717876DA → tx bytes 12,34,…,DA in order. `plaintext` must equal the injected ABCDEF01020304050607080900000000, with `done` pulsing once and `err_*`=0.
- Tx timing check: `uart_tx` falls at cycle 869 after `start`; every bit is 868 cycles; 32 frames; `busy` drops only after response.
- No response with RESP_TIMEOUT=50_000 → `done` and `err_timeout`=1 exactly 50_000 cycles after RESP entry; `plaintext`=0.
- Response byte 3 sent with a low stop bit → `err_frame`=1, all 16 bytes stored, `done` pulses normally.
- Glitch on `uart_rx` shorter than BAUD_TICKS/2 during RESP → no byte stored. Assert `start` mid-frame → ignored.
- Drop `rst_n` at byte 10 of tx → `uart_tx`=1 next cycle, all outputs at reset values. A new `start` then sends a full, correct 32-byte frame.

Source files
------------

// File: rtl/aes_frame_uart_initiator.sv
// Purpose : host-side initiator for the RSA/AES UART decrypt link. Sends a 32-byte request
//           (16 B RSA-wrapped key, then 16 B AES ciphertext) and collects the 16-byte plaintext reply.
// Latency : busy one cycle after start; first start bit at cycle 1+BAUD_TICKS; 11 bit times per
//           request byte; done one cycle after the stop sample of reply byte 15 (or on timeout).
// Backpressure: none; start is honoured only while idle (including the done cycle), never queued.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   start                 request a transaction (ignored while busy)
//   key_ct, data_ct       request payload, latched on an accepted start
//   uart_rx / uart_tx     serial reply / request lines (8N1, idle high, LSB first)
//   busy, done            transaction in progress / one-cycle end-of-transaction pulse
//   plaintext             reply, byte 0 in [127:120]
//   err_timeout           last transaction ended on reply timeout
//   err_frame             at least one reply byte had a low stop bit
module aes_frame_uart_initiator #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int BAUD_TICKS   = CLK_HZ / BAUD,
  parameter int RESP_TIMEOUT = 2_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_ct,
  input  logic [127:0] data_ct,
  input  logic         uart_rx,
  output logic         uart_tx,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext,
  output logic         err_timeout,
  output logic         err_frame
);

  localparam int CW = $clog2(BAUD_TICKS + 1);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_TICKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_TICKS / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RESP_TIMEOUT - 1);

  // Transaction / tx FSM
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  // Reply receiver FSM
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  logic [2:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [4:0]    tx_byte_q, tx_byte_d;
  logic [255:0]  tx_shreg_q, tx_shreg_d;
  logic          uart_tx_q, uart_tx_d;

  logic          rx_sync1_q, rx_sync1_d;
  logic          rx_sync2_q, rx_sync2_d;
  logic          rx_prev_q, rx_prev_d;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [3:0]    rx_nbytes_q, rx_nbytes_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic [127:0]  plaintext_q, plaintext_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_frame_q, err_frame_d;
  logic          done_q, done_d;

  logic          tx_tick;
  logic          rx_fall;
  logic [7:0]    tx_cur_byte;

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_bit_d      = tx_bit_q;
    tx_byte_d     = tx_byte_q;
    tx_shreg_d    = tx_shreg_q;
    rx_sync1_d    = uart_rx;
    rx_sync2_d    = rx_sync1_q;
    rx_prev_d     = rx_sync2_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_nbytes_d   = rx_nbytes_q;
    to_cnt_d      = to_cnt_q;
    plaintext_d   = plaintext_q;
    err_timeout_d = err_timeout_q;
    err_frame_d   = err_frame_q;
    done_d        = 1'b0;
    uart_tx_d     = 1'b1;
    tx_cur_byte   = 8'h00;

    tx_tick = (tx_cnt_q == BIT_LAST);
    rx_fall = rx_prev_q & ~rx_sync2_q;

    // ---------------- request transmitter ----------------
    case (tx_state_q)
      S_IDLE: begin
        if (start) begin
          tx_state_d    = S_GAP;
          tx_cnt_d      = '0;
          tx_bit_d      = 3'd0;
          tx_byte_d     = 5'd0;
          tx_shreg_d    = {key_ct, data_ct};
          plaintext_d   = '0;
          err_timeout_d = 1'b0;
          err_frame_d   = 1'b0;
          rx_nbytes_d   = 4'd0;
          to_cnt_d      = '0;
        end
      end
      S_GAP: begin
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        if (tx_tick) tx_state_d = S_START;
      end
      S_START: begin
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        if (tx_tick) begin
          tx_state_d = S_DATA;
          tx_bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        if (tx_tick) begin
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        if (tx_tick) begin
          if (tx_byte_q == 5'd31) begin
            tx_state_d = S_RESP;
            to_cnt_d   = '0;
          end else begin
            tx_state_d = S_GAP;
            tx_byte_d  = tx_byte_q + 5'd1;
            // Next byte moves to the top so the line always reads [255:248].
            tx_shreg_d = {tx_shreg_q[247:0], 8'h00};
          end
        end
      end
      default: ;  // S_RESP is driven entirely by the receiver below
    endcase

    // ---------------- reply receiver ----------------
    // Only live in RESP; line activity during the request is ignored.
    if (tx_state_q == S_RESP) begin
      case (rx_state_q)
        R_IDLE: begin
          if (to_cnt_q == TO_LAST) begin
            err_timeout_d = 1'b1;
            done_d        = 1'b1;
            tx_state_d    = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (rx_fall) begin
              rx_state_d = R_START;
              rx_cnt_d   = '0;
            end
          end
        end
        R_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d = '0;
            rx_bit_d = 3'd0;
            // Line back high at mid start bit: a glitch, not a byte.
            rx_state_d = rx_sync2_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        default: begin  // R_STOP
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = R_IDLE;
            // A low stop bit is flagged but the byte is kept.
            if (!rx_sync2_q) err_frame_d = 1'b1;
            for (int i = 0; i < 16; i++) begin
              if (rx_nbytes_q == 4'(i)) plaintext_d[8*(15-i) +: 8] = rx_shift_q;
            end
            rx_nbytes_d = rx_nbytes_q + 4'd1;
            to_cnt_d    = '0;
            if (rx_nbytes_q == 4'd15) begin
              done_d     = 1'b1;
              tx_state_d = S_IDLE;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
      endcase
    end else begin
      rx_state_d = R_IDLE;
    end

    // Line level is registered from the next-state view so uart_tx is glitch-free
    // and bit edges line up with state changes.
    tx_cur_byte = tx_shreg_d[255:248];
    case (tx_state_d)
      S_START: uart_tx_d = 1'b0;
      S_DATA:  uart_tx_d = tx_cur_byte[tx_bit_d];
      default: uart_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q    <= S_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= 3'd0;
      tx_byte_q     <= 5'd0;
      tx_shreg_q    <= '0;
      uart_tx_q     <= 1'b1;
      rx_sync1_q    <= 1'b1;
      rx_sync2_q    <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= R_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= 3'd0;
      rx_shift_q    <= 8'h00;
      rx_nbytes_q   <= 4'd0;
      to_cnt_q      <= '0;
      plaintext_q   <= '0;
      err_timeout_q <= 1'b0;
      err_frame_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_byte_q     <= tx_byte_d;
      tx_shreg_q    <= tx_shreg_d;
      uart_tx_q     <= uart_tx_d;
      rx_sync1_q    <= rx_sync1_d;
      rx_sync2_q    <= rx_sync2_d;
      rx_prev_q     <= rx_prev_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_nbytes_q   <= rx_nbytes_d;
      to_cnt_q      <= to_cnt_d;
      plaintext_q   <= plaintext_d;
      err_timeout_q <= err_timeout_d;
      err_frame_q   <= err_frame_d;
      done_q        <= done_d;
    end
  end

  assign uart_tx     = uart_tx_q;
  assign busy        = (tx_state_q != S_IDLE);
  assign done        = done_q;
  assign plaintext   = plaintext_q;
  assign err_timeout = err_timeout_q;
  assign err_frame   = err_frame_q;

endmodule
